// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter.
//   XLEN       : register data width
//   REG_ADDR_W : register-file address width
//   wb_req_t   : one pending register write (destination + data)
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of pending register writes with asynchronous reset.
// Ports:
//   clk, rst          : clock, async active-high reset
//   push, push_data   : enqueue request and payload (ignored when full)
//   pop               : dequeue request (ignored when empty)
//   head              : oldest entry
//   count, full, empty: occupancy
//   ent_valid, ent_rd : per-slot occupancy and destination, used to build pend_mask
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  wb_req_t                             push_data,
  input  logic                                pop,
  output wb_req_t                             head,
  output logic [$clog2(DEPTH):0]              count,
  output logic                                full,
  output logic                                empty,
  output logic [DEPTH-1:0]                    ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_rd
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i] = mem[i].rd;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr]       <= push_data;
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      // Push and pop never hit the same slot: that needs count==0 or count==DEPTH,
      // where one of them is blocked.
      if (pop_ok) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter feeding the single RegFile write port.
// The pipeline WB result always wins; long-latency results are queued in
// wb_fifo and drained on cycles the pipeline leaves the port free.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   wb_valid, wb_rd, wb_data      : in-order pipeline result (never stalled)
//   ll_valid, ll_ready, ll_rd,
//   ll_data                       : long-latency result handshake
//   RegWrite, rd, WriteData       : registered RegFile write port
//   pend_mask                     : registers targeted by queued entries
//   stall_req                     : queue starved for STARVE_LIMIT edges
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN         = wb_pkg::XLEN,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  ll_valid,
  output logic                  ll_ready,
  input  logic [REG_ADDR_W-1:0] ll_rd,
  input  logic [XLEN-1:0]       ll_data,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       WriteData,
  output logic [31:0]           pend_mask,
  output logic                  stall_req
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam int          SW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT   = SW'(STARVE_LIMIT);

  wb_req_t                         push_req;
  wb_req_t                         head;
  logic [AW:0]                     fifo_count;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [DEPTH-1:0]                ent_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
  logic                            push;
  logic                            pop;
  logic                            wb_take;
  logic [SW-1:0]                   starve_cnt;

  // Held low through reset; afterwards purely a function of occupancy.
  assign ll_ready = (fifo_count < DEPTH_CNT) && !rst;

  // x0 results complete the handshake but are never written, so drop them here.
  assign push          = ll_valid && ll_ready && !fifo_full && (ll_rd != '0);
  assign push_req.rd   = ll_rd;
  assign push_req.data = ll_data;

  assign wb_take = wb_valid && (wb_rd != '0);
  assign pop     = !wb_take && !fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) pend_mask[ent_rd[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite  <= 1'b0;
      rd        <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= wb_take || !fifo_empty;
      if (wb_take) begin
        rd        <= wb_rd;
        WriteData <= wb_data;
      end else if (pop) begin
        rd        <= head.rd;
        WriteData <= head.data;
      end
    end
  end

  // Counts edges on which a queued entry was blocked by a pipeline write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (fifo_empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign stall_req = (starve_cnt == LIMIT);

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        ll_valid = 1'b0;
  logic        ll_ready;
  logic [4:0]  ll_rd = '0;
  logic [31:0] ll_data = '0;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] WriteData;
  logic [31:0] pend_mask;
  logic        stall_req;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(32), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .ll_valid  (ll_valid),
    .ll_ready  (ll_ready),
    .ll_rd     (ll_rd),
    .ll_data   (ll_data),
    .RegWrite  (RegWrite),
    .rd        (rd),
    .WriteData (WriteData),
    .pend_mask (pend_mask),
    .stall_req (stall_req)
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  int      total = 0;
  int      bad   = 0;
  wb_req_t mq[$];
  exp_t    exp_q[$];
  int      mcnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: one expectation per driven cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("RegWrite", 32'(RegWrite), 32'(e.we));
      if (e.we) begin
        chk("rd", 32'(rd), 32'(e.rd));
        chk("WriteData", WriteData, e.data);
      end
    end
  end

  task automatic cyc(input logic wbv, input logic [4:0] wbr, input logic [31:0] wbd,
                     input logic llv, input logic [4:0] llr, input logic [31:0] lld,
                     output logic acc);
    exp_t        e;
    wb_req_t     h;
    wb_req_t     n;
    logic        take, had, ready;
    logic [31:0] p;
    @(negedge clk);
    wb_valid = wbv; wb_rd = wbr; wb_data = wbd;
    ll_valid = llv; ll_rd = llr; ll_data = lld;
    ready = (mq.size() < DEPTH);
    take  = wbv && (wbr != 0);
    had   = (mq.size() > 0);
    e.we = 1'b0; e.rd = '0; e.data = '0;
    if (take) begin
      e.we = 1'b1; e.rd = wbr; e.data = wbd;
    end else if (had) begin
      h = mq.pop_front();
      e.we = 1'b1; e.rd = h.rd; e.data = h.data;
    end
    if (!had || !take) mcnt = 0;
    else if (mcnt < LIMIT) mcnt++;
    acc = llv && ready;
    if (acc && llr != 0) begin
      n.rd = llr; n.data = lld;
      mq.push_back(n);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    p = '0;
    foreach (mq[i]) p[mq[i].rd] = 1'b1;
    chk("pend_mask", pend_mask, p);
    chk("ll_ready", 32'(ll_ready), 32'(mq.size() < DEPTH));
    chk("stall_req", 32'(stall_req), 32'(mcnt == LIMIT));
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wb_valid = 0; wb_rd = 0; wb_data = 0; ll_valid = 0; ll_rd = 0; ll_data = 0;
    #1;
    chk("rst_RegWrite", 32'(RegWrite), 0);
    chk("rst_pend_mask", pend_mask, 0);
    chk("rst_ll_ready", 32'(ll_ready), 0);
    chk("rst_stall_req", 32'(stall_req), 0);
    mq.delete();
    exp_q.delete();
    mcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ll_ready", 32'(ll_ready), 1);
    chk("post_rst_rd", 32'(rd), 0);
    chk("post_rst_WriteData", WriteData, 0);
  endtask

  initial begin
    logic acc;
    int   n;
    do_reset();

    // pipeline only, including an x0 result that must not write
    cyc(1, 5, 123, 0, 0, 0, acc);
    chk("wb_write_we", 32'(RegWrite), 1);
    chk("wb_write_rd", 32'(rd), 5);
    cyc(0, 0, 0, 0, 0, 0, acc);
    chk("wb_idle_we", 32'(RegWrite), 0);
    cyc(1, 0, 77, 0, 0, 0, acc);
    chk("wb_x0_we", 32'(RegWrite), 0);

    // long-latency only
    cyc(0, 0, 0, 1, 7, 32'hDEADBEEF, acc);
    chk("ll_pend7", 32'(pend_mask[7]), 1);
    chk("ll_no_bypass", 32'(RegWrite), 0);
    cyc(0, 0, 0, 0, 0, 0, acc);
    chk("ll_write_rd", 32'(rd), 7);
    chk("ll_pend7_clr", 32'(pend_mask[7]), 0);

    // x0 long-latency result accepted and dropped
    cyc(0, 0, 0, 1, 0, 32'h55, acc);
    chk("ll_x0_pend", pend_mask, 0);
    idle(1);

    // conflict: x9 queued, pipeline writes x3 then x4 first
    cyc(0, 0, 0, 1, 9, 32'h999, acc);
    cyc(1, 3, 32'h333, 0, 0, 0, acc);
    chk("conf_pend9_a", 32'(pend_mask[9]), 1);
    cyc(1, 4, 32'h444, 0, 0, 0, acc);
    chk("conf_pend9_b", 32'(pend_mask[9]), 1);
    cyc(0, 0, 0, 0, 0, 0, acc);
    chk("conf_rd9", 32'(rd), 9);

    // full / backpressure with a held third offer and pointer wrap
    cyc(1, 20, 32'h20, 1, 10, 32'hA10, acc);
    cyc(1, 21, 32'h21, 1, 11, 32'hA11, acc);
    chk("full_ll_ready", 32'(ll_ready), 0);
    n = 0;
    do begin
      cyc(n == 0, 22, 32'h22, 1, 12, 32'hA12, acc);
      n++;
    end while (!acc && n < 10);
    chk("held_offer_cycles", n, 3);
    idle(3);

    // starvation
    cyc(0, 0, 0, 1, 13, 32'hD13, acc);
    for (int i = 0; i < 4; i++) cyc(1, 5'(i + 1), 32'(i), 0, 0, 0, acc);
    chk("starve_set", 32'(stall_req), 1);
    cyc(1, 6, 32'h6, 0, 0, 0, acc);
    chk("starve_hold", 32'(stall_req), 1);
    cyc(0, 0, 0, 0, 0, 0, acc);
    chk("starve_pop_rd", 32'(rd), 13);
    chk("starve_clr", 32'(stall_req), 0);

    // reset mid-stream with two queued entries
    cyc(1, 2, 32'h2, 1, 14, 32'hE14, acc);
    cyc(1, 3, 32'h3, 1, 15, 32'hE15, acc);
    chk("pre_rst_pend", pend_mask, 32'h0000_C000);
    do_reset();
    idle(3);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, acc);
    end
    idle(4);
    chk("final_pend", pend_mask, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter that sits directly upstream of RegFile and drives its single write port (RegWrite, rd, WriteData).
- Merges two result sources:
  - the in-order pipeline WB result, which has absolute priority and is never stalled;
  - a long-latency source (load/mul-div) with a valid/ready handshake, buffered in a small FIFO.
- Also exports a pending-destination mask for the hazard unit, and a starvation stall request.

Parameters:
- XLEN, 32, data width.
- DEPTH, 2, long-latency FIFO entries (power of 2, >=2).
- STARVE_LIMIT, 4, consecutive blocked cycles before stall_req asserts.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_valid  in  1  pipeline result valid this cycle.
- wb_rd  in  5  pipeline destination register.
- wb_data  in  XLEN  pipeline result.
- ll_valid  in  1  long-latency result offered.
- ll_ready  out  1  arbiter can accept a long-latency result.
- ll_rd  in  5  long-latency destination register.
- ll_data  in  XLEN  long-latency result.
- RegWrite  out  1  RegFile write enable (registered).
- rd  out  5  RegFile write address (registered).
- WriteData  out  XLEN  RegFile write data (registered).
- pend_mask  out  32  bit i = 1 if any FIFO entry targets xi.
- stall_req  out  1  request to front-end to insert WB bubbles.

Behaviour:
- Reset (async on rst rise, held while rst=1):
  - RegWrite=0, rd=0, WriteData=0, stall_req=0, pend_mask=0, ll_ready=0.
  - FIFO emptied and starvation counter cleared.
  - Asserting rst mid-operation discards all queued entries; no partial write is issued.
  - ll_ready=1 from the first cycle after rst deasserts.
- ll_ready:
  - Asserted iff FIFO count < DEPTH. It depends only on registered state, never on ll_valid.
  - A transfer occurs when ll_valid && ll_ready at a rising edge.
  - A transfer with ll_rd=0 is accepted and dropped (not enqueued).
- Arbitration at each rising edge, in priority order:
  - wb_valid && wb_rd!=0: RegWrite<=1, rd<=wb_rd, WriteData<=wb_data. FIFO is not popped.
  - Otherwise, FIFO not empty: pop head; RegWrite<=1, rd<=head.rd, WriteData<=head.data.
  - Otherwise: RegWrite<=0; rd and WriteData hold their previous values.
  - wb_valid with wb_rd=0 does not occupy the port; the FIFO may drain that cycle.
- Latency:
  - Pipeline result is visible on RegWrite 1 cycle after presentation.
  - Long-latency result is visible at minimum 2 cycles after the handshake (enqueue edge, then pop edge). There is no FIFO bypass.
- Simultaneous push and pop on the same edge is legal when not full; count stays unchanged.
- Push when full is impossible because ll_ready=0.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- pend_mask:
  - Combinational OR of one-hot(rd) over valid FIFO entries.
  - An entry's bit clears in the cycle after its pop edge.
  - Duplicate rd entries keep the bit set until the last one pops.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each edge where the FIFO is non-empty and a valid non-x0 WB result blocks the pop.
  - Clears on any pop, or when the FIFO is empty.
  - stall_req = (counter == STARVE_LIMIT); it is a decode of a register, so it is glitch-free.
  - If wb_valid is still high while stall_req=1, WB still wins. No data is lost; the FIFO simply waits.
- WAW ordering between the two sources is guaranteed by the upstream scoreboard (which uses pend_mask). The arbiter performs no rd comparison.

Decomposition:
- Shared package wb_pkg:
  - constants XLEN=32 and REG_ADDR_W=5;
  - typedef wb_req_t packed struct {rd[4:0], data[XLEN-1:0]}.
- One natural sub-module: wb_fifo, a parameterised synchronous FIFO of wb_req_t with async reset. It exposes push, pop, head, count, full, empty and per-entry valid/rd for pend_mask.
- Arbitration, starvation counter and output registers live in wb_arbiter.

Test Plan:
- Reset: rst=1 mid-stream with 2 entries queued -> RegWrite=0, pend_mask=0, ll_ready=0 immediately; after release, ll_ready=1 and no stale write ever appears.
- Pipeline only: wb_valid=1, wb_rd=5, wb_data=123 at edge N -> RegWrite=1, rd=5, WriteData=123 after edge N; RegWrite=0 after N+1. wb_rd=0 -> RegWrite stays 0.
- LL only: ll_valid=1, ll_rd=7, ll_data=0xDEADBEEF accepted at edge N -> pend_mask[7]=1 after N; RegWrite=1, rd=7 after N+1; pend_mask[7]=0 after N+1.
- Conflict: LL rd=9 queued while wb_valid carries rd=3,4 on consecutive cycles -> writes in order x3, x4, x9; pend_mask[9] stays set until the x9 write.
- Full/backpressure (DEPTH=2): enqueue rd=10 and rd=11 while WB is continuously valid -> ll_ready=0 with 2 entries; a third offer is held (ll_valid stays high) and accepted only after a pop; FIFO order 10, 11, 12 is preserved across pointer wrap.
- Starvation: FIFO non-empty and WB valid (rd!=0) for 4 consecutive edges -> stall_req=1 after the 4th; drop wb_valid -> pop occurs and stall_req=0 the following cycle.
